// File: rtl/key_pkg.sv
// Shared types and helpers for the pushbutton debouncer.
package key_pkg;

    typedef enum logic [1:0] {
        UP     = 2'd0,
        CHK_DN = 2'd1,
        DOWN   = 2'd2,
        CHK_UP = 2'd3
    } key_state_e;

    // Counter width for a stable-sample count; never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 2)
            return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, 4-state FSM, stable-sample counter, pulses.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_db,
    output logic key_press,
    output logic key_release
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          REL_LVL  = (ACTIVE_LOW != 0);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    key_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          pressed;

    // Synchronized sample normalized so that 1 always means pressed.
    assign pressed = sync2_q ^ REL_LVL;

    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = '0;
        db_d    = db_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
            UP: begin
                if (pressed)
                    state_d = CHK_DN;
            end
            CHK_DN: begin
                if (!pressed) begin
                    state_d = UP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DOWN;
                    db_d    = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DOWN: begin
                if (!pressed)
                    state_d = CHK_UP;
            end
            CHK_UP: begin
                if (pressed) begin
                    state_d = DOWN;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = UP;
                    db_d    = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = UP;
            end
        endcase
    end

    // Synchronizer flops reset to the released pin level so no spurious press follows reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= REL_LVL;
            sync2_q <= REL_LVL;
            state_q <= UP;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign key_db      = db_q;
    assign key_press   = press_q;
    assign key_release = rel_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-channel pushbutton debouncer; one independent channel per key pin.
module key_debounce
    import key_pkg::*;
#(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_db,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .key_raw     (key_raw[i]),
            .key_db      (key_db[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with DEBOUNCE_CYCLES=8, N_KEYS=2, active-low keys.
module tb_key_debounce;

    localparam int LAT = 11;  // change before edge e+1 -> outputs update on edge e+11

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] key_raw = 2'b11;
    logic [1:0] key_db, key_press, key_release;

    int unsigned edge_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct packed {
        int unsigned edge_no;
        logic [1:0]  press;
        logic [1:0]  rel;
        logic [1:0]  db;
    } ev_t;

    ev_t exp_q[$];

    key_debounce #(
        .N_KEYS          (2),
        .DEBOUNCE_CYCLES (8),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_raw     (key_raw),
        .key_db      (key_db),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: every pulse must match the next expected event in time and value.
    always @(negedge clk) begin
        ev_t got, want;
        if (key_press != 2'b00 || key_release != 2'b00) begin
            got = '{edge_cnt, key_press, key_release, key_db};
            checks++;
            if (!reset_n) begin
                errors++;
                $display("FAIL pulse_in_reset edge=%0d press=%b release=%b required none",
                         edge_cnt, key_press, key_release);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse edge=%0d press=%b release=%b db=%b required none",
                         edge_cnt, key_press, key_release, key_db);
            end else begin
                want = exp_q.pop_front();
                if (got != want) begin
                    errors++;
                    $display("FAIL event got edge=%0d press=%b rel=%b db=%b required edge=%0d press=%b rel=%b db=%b",
                             got.edge_no, got.press, got.rel, got.db,
                             want.edge_no, want.press, want.rel, want.db);
                end
            end
        end
    end

    task automatic expect_ev(input int unsigned ed, input logic [1:0] p, input logic [1:0] r,
                             input logic [1:0] d);
        exp_q.push_back('{ed, p, r, d});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check2(input string name, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b required=%b", name, got, want);
        end
    endtask

    task automatic check_quiet(input string name);
        #1;
        check2({name, "_db"}, key_db, 2'b00);
        check2({name, "_press"}, key_press, 2'b00);
        check2({name, "_release"}, key_release, 2'b00);
    endtask

    initial begin
        int unsigned e;

        // Reset state
        step(3);
        check_quiet("reset");
        reset_n = 1'b1;
        step(4);
        check_quiet("idle");

        // Clean press of key 0
        key_raw = 2'b10;
        expect_ev(edge_cnt + LAT, 2'b01, 2'b00, 2'b01);
        step(16);
        #1 check2("press_db", key_db, 2'b01);

        // Release with a 5-cycle re-press glitch; count restarts from the final release
        step(1);
        key_raw = 2'b11;
        step(3);
        key_raw = 2'b10;
        step(5);
        #1 check2("glitch_db_held", key_db, 2'b01);
        key_raw = 2'b11;
        expect_ev(edge_cnt + LAT, 2'b00, 2'b01, 2'b00);
        step(16);
        #1 check2("release_db", key_db, 2'b00);

        // 3-cycle bounce: no change, no pulse
        step(1);
        key_raw = 2'b10;
        step(3);
        key_raw = 2'b11;
        step(16);
        #1 check2("bounce_db", key_db, 2'b00);

        // Staggered presses on both channels stay independent
        step(1);
        key_raw = 2'b10;
        expect_ev(edge_cnt + LAT, 2'b01, 2'b00, 2'b01);
        step(2);
        key_raw = 2'b00;
        expect_ev(edge_cnt + LAT, 2'b10, 2'b00, 2'b11);
        step(16);
        #1 check2("stagger_db", key_db, 2'b11);
        step(1);
        key_raw = 2'b11;
        expect_ev(edge_cnt + LAT, 2'b00, 2'b11, 2'b00);
        step(16);

        // Simultaneous press on both keys
        key_raw = 2'b00;
        expect_ev(edge_cnt + LAT, 2'b11, 2'b00, 2'b11);
        step(16);
        #1 check2("simul_db", key_db, 2'b11);
        step(1);
        key_raw = 2'b11;
        expect_ev(edge_cnt + LAT, 2'b00, 2'b11, 2'b00);
        step(16);

        // Reset mid-count with key 0 held, then debounce restarts after release of reset
        key_raw = 2'b10;
        step(6);
        reset_n = 1'b0;
        check_quiet("mid_reset");
        step(2);
        check_quiet("in_reset");
        reset_n = 1'b1;
        e = edge_cnt;
        expect_ev(e + LAT, 2'b01, 2'b00, 2'b01);
        step(LAT - 2);
        #1 check2("post_reset_early_db", key_db, 2'b00);
        step(7);
        #1 check2("post_reset_db", key_db, 2'b01);
        step(1);
        key_raw = 2'b11;
        expect_ev(edge_cnt + LAT, 2'b00, 2'b01, 2'b00);

        // Drain the scoreboard within a bounded window
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step(1);
        step(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got=%0d pending required=0", exp_q.size());
        end
        #1 check2("final_db", key_db, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL provide parameter N_KEYS, default 2: number of independent key channels.
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 500000: stable-sample count required to accept a level change (10 ms at 50 MHz); legal range >= 1.
REQ-003 SHALL provide parameter ACTIVE_LOW, default 1: 1 = raw key reads 0 when pressed.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port key_raw  input  N_KEYS  asynchronous pushbutton pins.
REQ-007 SHALL have port key_db  output  N_KEYS  debounced level, 1 = pressed, registered; feeds the key PIO in_port.
REQ-008 SHALL have port key_press  output  N_KEYS  one-cycle pulse on an accepted press.
REQ-009 SHALL have port key_release  output  N_KEYS  one-cycle pulse on an accepted release.

Function
REQ-010 SHALL pass each key_raw bit through a 2-flop synchronizer, then normalize it to pressed = 1 using ACTIVE_LOW; no other logic SHALL sample key_raw.
REQ-011 SHALL run one independent FSM and counter per channel, with counter width clog2(DEBOUNCE_CYCLES), minimum 1.
REQ-012 SHALL use FSM states UP, CHK_DN, DOWN and CHK_UP.
REQ-013 In UP, a synchronized pressed sample SHALL move the channel to CHK_DN and clear the counter.
REQ-014 In DOWN, a synchronized released sample SHALL move the channel to CHK_UP and clear the counter.
REQ-015 In CHK_DN, a pressed sample with counter == DEBOUNCE_CYCLES-1 SHALL move to DOWN, set key_db = 1 and assert key_press for exactly one cycle; a pressed sample with a smaller count SHALL increment the counter.
REQ-016 In CHK_DN, any released sample SHALL return the channel to UP and clear the counter, with no output change.
REQ-017 CHK_UP SHALL mirror CHK_DN: acceptance moves to UP, sets key_db = 0 and pulses key_release; a bounce returns to DOWN.
REQ-018 Latency: for a clean change of key_raw before clock edge 1, key_db and the pulse SHALL update on edge DEBOUNCE_CYCLES+3 and not earlier.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no key_db change and no pulse.
REQ-020 The counter SHALL never wrap: it SHALL saturate only via a state exit, and SHALL hold 0 in UP and DOWN.
REQ-021 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-022 key_press and key_release of one channel SHALL never assert in the same cycle.

Reset
REQ-023 reset_n low SHALL asynchronously force every FSM to UP, every counter to 0, key_db/key_press/key_release to 0, and synchronizer flops to the released level (1 if ACTIVE_LOW, else 0).
REQ-024 Reset asserted mid-CHK_DN or mid-CHK_UP SHALL discard the partial count and emit no pulse.
REQ-025 A key held through reset release SHALL be debounced normally afterwards, producing key_db = 1 and one key_press at edge DEBOUNCE_CYCLES+3 after reset deassertion.

Structure
REQ-026 The FSM state enum and the clog2-based counter-width function SHALL live in the shared package key_pkg.
REQ-027 The per-channel synchronizer, FSM, counter and pulse logic SHALL be the sub-module key_debounce_ch, instantiated N_KEYS times by a generate loop in key_debounce.

Verification (DEBOUNCE_CYCLES = 8, N_KEYS = 2, ACTIVE_LOW = 1)
REQ-028 Clean press: key_raw[0] 1->0 before edge 1 -> key_db[0] = 1 and key_press[0] = 1 exactly at edge 11, with key_press[0] = 0 at edge 12.
REQ-029 Bounce: key_raw[0] low for 3 cycles then high -> key_db and key_press stay 0 throughout; the FSM returns to UP.
REQ-030 Release: from DOWN, key_raw[0] 0->1 -> key_db[0] = 0 and one key_release[0] pulse at edge 11; a 5-cycle re-press glitch during CHK_UP restarts the count.
REQ-031 Simultaneous: both keys pressed on the same edge -> key_press = 2'b11 for one cycle at edge 11 and key_db = 2'b11.
REQ-032 Reset mid-count: reset_n pulsed low at edge 6 of CHK_DN with key held -> all outputs 0 during reset; after release, key_press fires at edge 11 post-reset.
